// File: rtl/dac_buf_pkg.sv
// Shared definitions for the FSMC-attached capture/playback buffers:
// bus sequencer states, register map and status bit positions.
package dac_buf_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_JUDGE,
    BUS_READ,
    BUS_WRITE
  } bus_state_e;

  localparam logic [15:0] BUF_CTRL_ADDR = 16'h4000;
  localparam logic [15:0] BUF_LEN_ADDR  = 16'h4001;

  localparam int unsigned STAT_RUNNING_BIT = 0;
  localparam int unsigned STAT_PENDING_BIT = 1;
  localparam int unsigned CTRL_COMMIT_BIT  = 0;

endpackage

// File: rtl/fsmc_slave_if.sv
// FSMC-style slave: address on en rising, write data on en falling,
// read data driven for as long as en stays high.
module fsmc_slave_if
  import dac_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  state,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  wr_stb,
  output logic [DATA_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  bus_state_e            cur_state;
  bus_state_e            nxt_state;
  logic                  en_prev;
  logic                  en_rise;
  logic                  en_fall;
  logic                  addr_ld;
  logic                  rd_drive;
  logic                  out_clr;
  logic [DATA_WIDTH-1:0] addr_q;

  assign en_rise = en & ~en_prev;
  assign en_fall = ~en & en_prev;

  always_ff @(posedge clk) begin
    if (rst) cur_state <= BUS_IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      BUS_IDLE:  if (en_rise) nxt_state = BUS_JUDGE;
      BUS_JUDGE: nxt_state = state ? BUS_READ : BUS_WRITE;
      BUS_WRITE: if (en_fall) nxt_state = BUS_IDLE;
      BUS_READ:  if (!en) nxt_state = BUS_IDLE;
      default:   nxt_state = BUS_IDLE;
    endcase
  end

  always_comb begin
    addr_ld  = 1'b0;
    wr_stb   = 1'b0;
    rd_drive = 1'b0;
    out_clr  = 1'b0;
    case (cur_state)
      BUS_IDLE: begin
        out_clr = 1'b1;
        addr_ld = en_rise;
      end
      BUS_WRITE: wr_stb   = en_fall;
      BUS_READ:  rd_drive = en;
      default: ;
    endcase
  end

  // en_prev follows en even in reset so a chip-enable held across reset
  // release is not mistaken for a fresh access.
  always_ff @(posedge clk) begin
    en_prev <= en;
    if (rst) begin
      addr_q  <= '0;
      bus_out <= '0;
    end else begin
      if (addr_ld) addr_q <= bus_in;
      if (out_clr)       bus_out <= '0;
      else if (rd_drive) bus_out <= rd_data;
    end
  end

  assign wr_addr = addr_q;
  assign rd_addr = addr_q;
  assign wr_data = bus_in;

endmodule

// File: rtl/dac_playback_buffer.sv
// Double-buffered DAC waveform player: the MCU fills the idle buffer over
// the FSMC bus and commits it; buffers swap only at a loop boundary.
module dac_playback_buffer
  import dac_buf_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           DAC_WIDTH  = 12,
  parameter int unsigned           BUF_SIZE   = 1024,
  parameter logic [DATA_WIDTH-1:0] CTRL_ADDR  = DATA_WIDTH'(BUF_CTRL_ADDR),
  parameter logic [DATA_WIDTH-1:0] LEN_ADDR   = DATA_WIDTH'(BUF_LEN_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dac_clk,
  input  logic                  en,
  input  logic                  state,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic [DAC_WIDTH-1:0]  dac_data,
  output logic                  running
);

  localparam int unsigned           PTR_W      = $clog2(BUF_SIZE);
  localparam int unsigned           LEN_W      = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] BUF_SIZE_D = DATA_WIDTH'(BUF_SIZE);
  localparam logic [LEN_W-1:0]      BUF_SIZE_L = LEN_W'(BUF_SIZE);

  logic [DAC_WIDTH-1:0]  mem [2*BUF_SIZE];

  logic                  wr_stb;
  logic [DATA_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  dac_meta;
  logic [1:0]            dac_sync;
  logic                  dac_rise;
  logic                  tick;

  logic                  play_buf;
  logic                  swap_pending;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LEN_W-1:0]      len;
  logic [LEN_W-1:0]      len_shadow;
  logic [LEN_W-1:0]      len_clamped;

  logic                  wrap;
  logic                  do_swap;
  logic                  commit;
  logic                  wr_fill;
  logic                  wr_len;

  fsmc_slave_if #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bus (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .state   (state),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign dac_rise = (dac_sync == 2'b01);
  assign tick     = dac_rise & running;
  assign wrap     = ({1'b0, rd_ptr} == len - LEN_W'(1));

  // Swap is decided from the registered pending flag, so a commit landing
  // on a wrap edge only takes effect at the following wrap.
  assign do_swap  = swap_pending & (~running | (tick & wrap));

  assign wr_fill  = wr_stb & ~rst & (wr_addr < BUF_SIZE_D) & ~swap_pending;
  assign wr_len   = wr_stb & (wr_addr == LEN_ADDR);
  assign commit   = wr_stb & (wr_addr == CTRL_ADDR) & wr_data[CTRL_COMMIT_BIT] & ~swap_pending;

  assign len_clamped = ((wr_data == '0) || (wr_data > BUF_SIZE_D)) ? BUF_SIZE_L
                                                                   : wr_data[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (wr_fill) mem[{~play_buf, wr_addr[PTR_W-1:0]}] <= wr_data[DAC_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_meta <= 1'b0;
      dac_sync <= '0;
    end else begin
      dac_meta <= dac_clk;
      dac_sync <= {dac_sync[0], dac_meta};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data     <= '0;
      running      <= 1'b0;
      play_buf     <= 1'b0;
      rd_ptr       <= '0;
      len          <= BUF_SIZE_L;
      len_shadow   <= BUF_SIZE_L;
      swap_pending <= 1'b0;
    end else begin
      if (wr_len) len_shadow <= len_clamped;

      if (tick) begin
        dac_data <= mem[{play_buf, rd_ptr}];
        rd_ptr   <= wrap ? '0 : rd_ptr + PTR_W'(1);
      end

      if (do_swap) begin
        play_buf     <= ~play_buf;
        len          <= len_shadow;
        rd_ptr       <= '0;
        running      <= 1'b1;
        swap_pending <= 1'b0;
      end else if (commit) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '1;
    if (rd_addr < BUF_SIZE_D) begin
      rd_data = DATA_WIDTH'(mem[{~play_buf, rd_addr[PTR_W-1:0]}]);
    end else if (rd_addr == CTRL_ADDR) begin
      rd_data                   = '0;
      rd_data[STAT_PENDING_BIT] = swap_pending;
      rd_data[STAT_RUNNING_BIT] = running;
    end else if (rd_addr == LEN_ADDR) begin
      rd_data = DATA_WIDTH'(len);
    end
  end

endmodule

// File: tb/tb_dac_playback_buffer.sv
// Scoreboard bench for dac_playback_buffer: stimulus queues expected bus
// reads and DAC samples, two monitors pop and compare them.
module tb_dac_playback_buffer;

  localparam logic [15:0] CTRL = 16'h4000;
  localparam logic [15:0] LEN  = 16'h4001;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        dac_clk = 1'b0;
  logic        en      = 1'b0;
  logic        state   = 1'b0;
  logic [15:0] bus_in  = '0;
  logic [15:0] bus_out;
  logic [11:0] dac_data;
  logic        running;

  dac_playback_buffer #(
    .DATA_WIDTH (16),
    .DAC_WIDTH  (12),
    .BUF_SIZE   (1024),
    .CTRL_ADDR  (16'h4000),
    .LEN_ADDR   (16'h4001)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dac_clk  (dac_clk),
    .en       (en),
    .state    (state),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .dac_data (dac_data),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] data;
    logic        run;
  } dac_exp_t;

  dac_exp_t    dac_q[$];
  logic [15:0] rd_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [11:0] last_dac    = '0;
  event        rd_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // DAC monitor: previous sample must hold two clk edges after the rise,
  // new sample must appear on the third.
  initial begin
    dac_exp_t e;
    forever begin
      @(posedge dac_clk);
      repeat (2) @(posedge clk);
      #1 check("dac_hold", 32'(dac_data), 32'(last_dac));
      @(posedge clk);
      #1;
      if (dac_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dac_unexpected: got %0h expected no sample", dac_data);
      end else begin
        e = dac_q.pop_front();
        check("dac_data", 32'(dac_data), 32'(e.data));
        check("running", 32'(running), 32'(e.run));
        last_dac = e.data;
      end
    end
  end

  initial begin
    forever begin
      @(rd_ev);
      if (rd_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL bus_unexpected: got %0h expected no read", bus_out);
      end else begin
        check("bus_read", 32'(bus_out), 32'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    state  = 1'b0;
    bus_in = addr;
    en     = 1'b1;
    repeat (2) @(negedge clk);
    bus_in = data;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp);
    rd_q.push_back(exp);
    @(negedge clk);
    state  = 1'b1;
    bus_in = addr;
    en     = 1'b1;
    repeat (5) @(negedge clk);
    ->rd_ev;
    @(negedge clk);
    en    = 1'b0;
    state = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic dac_tick(input logic [11:0] exp, input logic run);
    dac_exp_t e;
    e.data = exp;
    e.run  = run;
    dac_q.push_back(e);
    @(negedge clk);
    dac_clk = 1'b1;
    repeat (6) @(negedge clk);
    dac_clk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    last_dac = '0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bus_read(CTRL, 16'h0000);
    repeat (10) dac_tick(12'd0, 1'b0);

    // buffer A: 100..107, length 8
    for (int i = 0; i < 8; i++) bus_write(16'(i), 16'(100 + i));
    bus_write(LEN, 16'd8);
    bus_write(CTRL, 16'h0001);
    bus_read(CTRL, 16'h0001);
    for (int i = 0; i < 9; i++) dac_tick(12'(100 + (i % 8)), 1'b1);

    // buffer B: 500..503, length 4, committed mid-loop
    for (int i = 0; i < 4; i++) bus_write(16'(i), 16'(500 + i));
    bus_write(LEN, 16'd4);
    bus_write(CTRL, 16'h0001);
    bus_read(CTRL, 16'h0003);
    bus_write(16'd2, 16'd999);
    bus_read(16'd2, 16'd502);
    bus_write(CTRL, 16'h0001);
    for (int i = 1; i < 8; i++) dac_tick(12'(100 + i), 1'b1);
    for (int i = 0; i < 5; i++) dac_tick(12'(500 + (i % 4)), 1'b1);
    bus_read(CTRL, 16'h0001);
    bus_read(LEN, 16'd4);
    bus_read(16'd0, 16'd100);

    // oversize length clamps; back to A at the B wrap
    bus_write(LEN, 16'd2000);
    bus_write(CTRL, 16'h0001);
    for (int i = 1; i < 4; i++) dac_tick(12'(500 + i), 1'b1);
    dac_tick(12'd100, 1'b1);
    bus_read(LEN, 16'd1024);
    bus_read(16'h5000, 16'hFFFF);
    bus_read(16'h0400, 16'hFFFF);
    bus_read(CTRL, 16'h0001);

    // reset in the middle of a write to B[3] while A is playing
    @(negedge clk);
    state  = 1'b0;
    bus_in = 16'd3;
    en     = 1'b1;
    repeat (2) @(negedge clk);
    bus_in = 16'd777;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    last_dac = '0;
    @(negedge clk);
    bus_read(CTRL, 16'h0000);
    dac_tick(12'd0, 1'b0);
    dac_tick(12'd0, 1'b0);

    // zero length clamps; immediate start when idle
    bus_write(LEN, 16'd5);
    bus_write(LEN, 16'd0);
    bus_write(CTRL, 16'h0001);
    bus_read(CTRL, 16'h0001);
    bus_read(LEN, 16'd1024);
    bus_read(16'd3, 16'd503);
    dac_tick(12'd100, 1'b1);

    // length 1: swaps can happen on every rise
    do_reset();
    bus_write(16'd0, 16'd42);
    bus_write(LEN, 16'd1);
    bus_write(CTRL, 16'h0001);
    dac_tick(12'd42, 1'b1);
    dac_tick(12'd42, 1'b1);
    bus_write(16'd0, 16'd77);
    bus_write(LEN, 16'd1);
    bus_write(CTRL, 16'h0001);
    bus_read(CTRL, 16'h0003);
    dac_tick(12'd42, 1'b1);
    dac_tick(12'd77, 1'b1);
    dac_tick(12'd77, 1'b1);
    bus_write(CTRL, 16'h0001);
    dac_tick(12'd77, 1'b1);
    dac_tick(12'd42, 1'b1);

    repeat (20) @(negedge clk);
    check("dac_queue_left", 32'(dac_q.size()), 32'd0);
    check("rd_queue_left", 32'(rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_playback_buffer.md
Name: dac_playback_buffer

Overview:
- Double-buffered waveform playback block, the output-side counterpart of the ADC capture buffer.
- The MCU writes samples over the FSMC-style bus into the idle "fill" buffer, then commits it.
- The block loops the "play" buffer to the DAC, one sample per dac_clk rising edge.
- Buffers swap only at a loop boundary, so playback never tears mid-waveform.

Parameters:
- DATA_WIDTH, 16, bus data/address width.
- DAC_WIDTH, 12, DAC sample width.
- BUF_SIZE, 1024, depth of each buffer, power of two.
- CTRL_ADDR, 16'h4000, control/status register address.
- LEN_ADDR, 16'h4001, playback-length register address.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- dac_clk  in  1  DAC sample clock; asynchronous, slower than clk/4.
- en  in  1  bus chip-enable; one access per high pulse.
- state  in  1  0 = MCU writes to block, 1 = MCU reads from block.
- bus_in  in  DATA_WIDTH  address on en rising, write data on en falling.
- bus_out  out  DATA_WIDTH  read data.
- dac_data  out  DAC_WIDTH  sample to DAC.
- running  out  1  high once a buffer has been committed and is playing.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high.
- On rst: bus_out=0, dac_data=0, running=0, play_buf=0, rd_ptr=0, len=BUF_SIZE, swap_pending=0, bus FSM=IDLE. Buffer RAM contents are not cleared.
- dac_clk sync: 2-flop synchroniser, then rise = (sync[1:0]==2'b01).
- On a clk edge where rise=1 and running=1:
  - dac_data <= play buffer[rd_ptr].
  - rd_ptr <= (rd_ptr==len-1) ? 0 : rd_ptr+1.
  - Net latency: dac_data changes on the 3rd clk edge after dac_clk rises.
- When running=0, dac_data holds 0.
- Bus FSM states: IDLE -> JUDGE -> WRITE or READ -> IDLE.
  - IDLE: on en rising (en & ~en_prev), latch addr <= bus_in, go to JUDGE. bus_out <= 0.
  - JUDGE: one cycle. state=0 -> WRITE (MCU writes); state=1 -> READ (MCU reads).
  - WRITE: on en falling, commit bus_in to addr, then go to IDLE.
  - READ: drive bus_out every cycle while en=1; go to IDLE on en=0.
- Write decode:
  - addr < BUF_SIZE: fill_buf[addr] <= bus_in[DAC_WIDTH-1:0], where fill_buf = ~play_buf. Ignored while swap_pending=1.
  - LEN_ADDR: len_shadow <= bus_in. Values 0 or >BUF_SIZE clamp to BUF_SIZE.
  - CTRL_ADDR, bus_in[0]=1: swap_pending <= 1. A commit while already pending is ignored. bus_in[0]=0 has no effect.
  - Any other address: ignored.
- Read decode:
  - addr < BUF_SIZE: {zero-extend, fill_buf[addr]}.
  - CTRL_ADDR: {14'b0, swap_pending, running}.
  - LEN_ADDR: active len.
  - Any other address: 16'hFFFF.
- Swap rules:
  - running=0 and swap_pending=1: next clk, play_buf <= ~play_buf, len <= len_shadow, rd_ptr <= 0, running <= 1, swap_pending <= 0.
  - running=1: the swap happens on the same clk edge that outputs sample len-1 (rd_ptr wraps). The next rise plays new buffer index 0.
  - A commit arriving in the same cycle as a wrap does not swap on that wrap. It waits for the next wrap.
- len=1: the same sample repeats; a swap can occur on every rise.
- rst mid-access: the FSM returns to IDLE and the partial access is dropped.

Decomposition:
- Package dac_buf_pkg:
  - bus FSM enum (BUS_IDLE, BUS_JUDGE, BUS_READ, BUS_WRITE).
  - CTRL_ADDR and LEN_ADDR constants.
  - Status bit indices.
  - Shared with the capture buffer.
- Sub-module fsmc_slave_if: en edge detection, address latch, and the JUDGE/READ/WRITE sequencing. Outputs wr_stb/wr_addr/wr_data and a rd_addr/rd_data hookup. Reusable by the capture block.

Test Plan:
- Reset, then read CTRL_ADDR -> bus_out=16'h0000. Toggle dac_clk 10 times -> dac_data stays 0, running=0.
- Write samples 0..7 = 100..107, LEN=8, CTRL bit0=1 -> running=1. Successive dac_clk rises give 100,101,...,107,100, each 3 clk after the rise.
- While buffer A loops, fill B with 500..503, LEN=4, commit. CTRL read shows bit1=1; A continues to 107, then 500,501,502,503,500; bit1 then reads 0.
- While swap_pending=1, write 999 to addr 2 -> ignored. After the swap, B plays 502 at index 2. A second commit while pending leaves a single swap.
- Write LEN=0 and LEN=2000 -> LEN_ADDR reads 1024. Read addr 16'h5000 -> 16'hFFFF.
- Assert rst during a WRITE access and mid-playback -> all outputs 0, running=0. The aborted write has no effect.
